stream_frame_writer: RTL and testbench

//  Sink end of the raster pixel stream (sof/eol/valid/ready) produced by the coordinate/pixel pipeline.

---
 rtl/stream_frame_writer_pkg.sv | 13 +
 rtl/stream_frame_writer_pos.sv | 59 +++++
 rtl/stream_frame_writer.sv | 120 ++++++++++++
 tb/tb_stream_frame_writer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_frame_writer_pkg.sv
// Shared geometry defaults and FSM encoding
// for the raster stream frame writer.
package stream_frame_writer_pkg;

  localparam int X_SIZE_DEF = 640;
  localparam int Y_SIZE_DEF = 480;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/stream_frame_writer_pos.sv
// Raster position tracker: col/row plus an
// incrementally maintained linear address.
module stream_frame_writer_pos #(
  parameter int X_SIZE = 640,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              restart,
  input  logic              line_end,
  input  logic              clear,
  output logic [15:0]       col,
  output logic [15:0]       row,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] row_base;
  logic [15:0]       row_e;
  logic [ADDR_W-1:0] base_e;
  logic [ADDR_W-1:0] addr_e;
  logic [15:0]       col_e;

  // restart treats the current beat as (0,0)
  always_comb begin
    col_e  = restart ? '0 : col;
    row_e  = restart ? '0 : row;
    base_e = restart ? '0 : row_base;
    addr_e = restart ? '0 : addr;
  end

  // advance past the current beat
  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (step) begin
      if (clear) begin
        col      <= '0;
        row      <= '0;
        row_base <= '0;
        addr     <= '0;
      end else if (line_end) begin
        col      <= '0;
        row      <= row_e + 16'd1;
        row_base <= base_e + ADDR_W'(X_SIZE);
        addr     <= base_e + ADDR_W'(X_SIZE);
      end else begin
        col      <= col_e + 16'd1;
        row      <= row_e;
        row_base <= base_e;
        addr     <= addr_e + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/stream_frame_writer.sv
// Pixel stream sink: frames beats into linear
// framebuffer writes and checks stream framing.
module stream_frame_writer
  import stream_frame_writer_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_we,
  input  logic              m_ready,
  output logic              frame_done,
  output logic              sof_err,
  output logic              eol_err,
  output logic [15:0]       frame_count
);

  state_t            state;
  state_t            state_n;
  logic [15:0]       col;
  logic [15:0]       row;
  logic [ADDR_W-1:0] addr;
  logic              beat;
  logic              write;
  logic              resync;
  logic              at_last;
  logic              line_end;
  logic              fdone;
  logic              sof_e;
  logic              eol_e;
  logic [15:0]       col_e;
  logic [15:0]       row_e;
  logic [ADDR_W-1:0] waddr;

  assign s_ready = !m_we || m_ready;

  stream_frame_writer_pos #(
    .X_SIZE (X_SIZE),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .step     (write),
    .restart  (resync),
    .line_end (line_end),
    .clear    (fdone),
    .col      (col),
    .row      (row),
    .addr     (addr)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_SOF;
    else       state <= state_n;
  end

  // next state
  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_SOF: if (write && !fdone) state_n = ACTIVE;
      ACTIVE:   if (fdone) state_n = WAIT_SOF;
      default:  state_n = WAIT_SOF;
    endcase
  end

  // beat decode, sof resync and framing checks
  always_comb begin
    beat     = s_valid && s_ready;
    write    = beat && (state == ACTIVE || s_sof);
    resync   = write && s_sof;
    sof_e    = beat && state == ACTIVE && s_sof
               && (col != '0 || row != '0);
    col_e    = resync ? '0 : col;
    row_e    = resync ? '0 : row;
    waddr    = resync ? '0 : addr;
    at_last  = col_e == 16'(X_SIZE - 1);
    line_end = s_eol || at_last;
    eol_e    = write && (s_eol != at_last);
    fdone    = write && line_end
               && row_e == 16'(Y_SIZE - 1);
  end

  // write register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
      frame_done  <= 1'b0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= fdone;
      sof_err    <= sof_e;
      eol_err    <= eol_e;
      if (fdone) frame_count <= frame_count + 16'd1;
      if (s_ready) begin
        m_we <= write;
        if (write) begin
          m_addr <= waddr;
          m_data <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_frame_writer.sv
// Directed bench for stream_frame_writer on a
// reduced 64x48 raster.
module tb_stream_frame_writer;

  localparam int XS = 64;
  localparam int YS = 48;
  localparam int DW = 24;
  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_eol;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_we;
  logic          m_ready;
  logic          frame_done;
  logic          sof_err;
  logic          eol_err;
  logic [15:0]   frame_count;

  stream_frame_writer #(
    .X_SIZE (XS),
    .Y_SIZE (YS),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_eol       (s_eol),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_we        (m_we),
    .m_ready     (m_ready),
    .frame_done  (frame_done),
    .sof_err     (sof_err),
    .eol_err     (eol_err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int pass  = 0;
  int tcol  = 0;

  logic mon_en = 1'b0;
  int   exp_addr;
  int   wr_cnt;
  int   seq_err;
  int   fd_cnt;

  typedef struct {
    logic          v;
    logic          sof;
    logic          eol;
    logic          mr;
    logic [DW-1:0] d;
    logic          e_rdy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_serr;
    logic          e_eerr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic b(input logic [DW-1:0] d,
                   input logic sof,
                   input logic eol);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      b(DW'(i + 7), 1'b0, tcol == XS - 1);
      tcol = (tcol == XS - 1) ? 0 : tcol + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tcol  = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (m_we && m_ready) begin
        if (32'(m_addr) != exp_addr ||
            32'(m_data) != exp_addr)
          seq_err++;
        exp_addr++;
        wr_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    s_data  = '0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;

    tbl[0]  = '{1,0,0,1,24'hA1,1,0,0,0,0,0};
    tbl[1]  = '{1,0,0,1,24'hA2,1,0,0,0,0,0};
    tbl[2]  = '{1,0,0,1,24'hA3,1,0,0,0,0,0};
    tbl[3]  = '{1,1,0,1,24'h55,1,1,0,24'h55,0,0};
    tbl[4]  = '{1,0,0,0,24'h66,0,1,0,24'h55,0,0};
    tbl[5]  = '{1,0,0,1,24'h66,1,1,1,24'h66,0,0};
    tbl[6]  = '{0,0,0,1,24'h00,1,0,0,0,0,0};
    tbl[7]  = '{1,0,1,1,24'h77,1,1,2,24'h77,0,1};
    tbl[8]  = '{1,0,0,1,24'h88,1,1,64,24'h88,0,0};
    tbl[9]  = '{1,1,0,1,24'h99,1,1,0,24'h99,1,0};
    tbl[10] = '{1,0,0,1,24'hAA,1,1,1,24'hAA,0,0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(m_we), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_fcnt", 32'(frame_count), 0);
    chk("rst_rdy", 32'(s_ready), 1);
    chk("rst_pulses",
        32'({frame_done, sof_err, eol_err}), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s_valid = tbl[i].v;
      s_sof   = tbl[i].sof;
      s_eol   = tbl[i].eol;
      s_data  = tbl[i].d;
      m_ready = tbl[i].mr;
      #1;
      chk($sformatf("v%0d_rdy", i),
          32'(s_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i),
          32'(m_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_addr", i),
            32'(m_addr), 32'(tbl[i].e_addr));
        chk($sformatf("v%0d_data", i),
            32'(m_data), 32'(tbl[i].e_data));
      end
      chk($sformatf("v%0d_soferr", i),
          32'(sof_err), 32'(tbl[i].e_serr));
      chk($sformatf("v%0d_eolerr", i),
          32'(eol_err), 32'(tbl[i].e_eerr));
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    m_ready = 1'b1;

    do_reset();
    exp_addr = 0;
    wr_cnt   = 0;
    seq_err  = 0;
    fd_cnt   = 0;
    mon_en   = 1'b1;
    for (int i = 0; i < XS * YS; i++) begin
      b(DW'(i), i == 0, tcol == XS - 1);
      tcol = (tcol == XS - 1) ? 0 : tcol + 1;
      if (i == 1000) begin
        chk("stall_pre_addr", 32'(m_addr), 1000);
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          #1;
          chk($sformatf("stall%0d_rdy", s),
              32'(s_ready), 0);
          chk($sformatf("stall%0d_addr", s),
              32'(m_addr), 1000);
          chk($sformatf("stall%0d_we", s),
              32'(m_we), 1);
        end
        m_ready = 1'b1;
      end
      if (i == XS * YS - 1)
        chk("last_fdone", 32'(frame_done), 1);
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("frame_writes", 32'(wr_cnt), XS * YS);
    chk("frame_seq_err", 32'(seq_err), 0);
    chk("frame_done_cnt", 32'(fd_cnt), 1);
    chk("frame_count", 32'(frame_count), 1);
    chk("idle_we", 32'(m_we), 0);

    tcol = 0;
    b(DW'(0), 1'b1, 1'b0);
    tcol = 1;
    run(2 * XS - 1);
    run(10);
    b(DW'(500), 1'b0, 1'b1);
    chk("early_eol_err", 32'(eol_err), 1);
    chk("early_eol_addr", 32'(m_addr), 2 * XS + 10);
    tcol = 0;
    b(DW'(501), 1'b0, 1'b0);
    chk("after_eol_addr", 32'(m_addr), 3 * XS);
    chk("after_eol_err", 32'(eol_err), 0);
    tcol = 1;
    run(7 * XS + 4);
    b(DW'(600), 1'b1, 1'b0);
    chk("sof_err", 32'(sof_err), 1);
    chk("sof_addr", 32'(m_addr), 0);
    chk("sof_data", 32'(m_data), 600);
    chk("sof_no_eolerr", 32'(eol_err), 0);
    tcol = 1;
    b(DW'(601), 1'b0, 1'b0);
    chk("post_sof_addr", 32'(m_addr), 1);
    chk("post_sof_err", 32'(sof_err), 0);
    tcol = 2;
    run(20 * XS - 2);
    chk("pre_rst_we", 32'(m_we), 1);
    chk("pre_rst_addr", 32'(m_addr), 20 * XS - 1);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_we", 32'(m_we), 0);
    chk("midrst_fcnt", 32'(frame_count), 0);
    chk("midrst_addr", 32'(m_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    b(DW'(5), 1'b0, 1'b0);
    chk("wait_discard_we", 32'(m_we), 0);
    b(DW'(9), 1'b1, 1'b0);
    chk("resof_we", 32'(m_we), 1);
    chk("resof_addr", 32'(m_addr), 0);
    chk("resof_data", 32'(m_data), 9);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
